// File: rtl/ram_infr.sv
// ram_infr: single-port synchronous RAM with inferred storage and a registered
// read port in no-change mode.
//
// The array is left free of reset logic so that synthesis can map it onto
// block or distributed RAM. The read port is a real register and is never a
// combinational read. A write leaves the output register untouched. The
// output register changes only on an enabled read (en=1, we=0).
//
// Optional feature: define RAM_INFR_OUT_REG_EN to add a second output
// pipeline register. Read latency then becomes 2 cycles. The second stage
// loads only when the first stage was updated by a read on the previous edge,
// so the no-change behaviour carries through the pipeline. When the macro is
// undefined (the default), read latency is 1 cycle.
//
// Parameters:
//   DATA_WIDTH  word width in bits (default 4)
//   ADDR_WIDTH  address width; depth = 2**ADDR_WIDTH (default 5 -> 32 words)
//
// Ports:
//   clk   sole clock, rising edge
//   rst   asynchronous active-high reset; clears the output register(s) only
//   en    port enable; gates both read and write
//   we    write enable, qualified by en
//   addr  word address
//   di    write data
//   dout  registered read data. The obvious name "do" is a SystemVerilog
//         keyword, so the port is called dout.

module ram_infr #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] di,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] do_int;
  logic                  wr_fire;
  logic                  rd_fire;

  // rst blocks both ports while it is high, even though the array itself is
  // never cleared.
  assign wr_fire = en &  we & ~rst;
  assign rd_fire = en & ~we;

  // Storage: no reset, so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[addr] <= di;
  end

  // First read stage. It loads only on a read, which gives no-change mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          do_int <= '0;
    else if (rd_fire) do_int <= mem[addr];
  end

`ifdef RAM_INFR_OUT_REG_EN
  localparam int STAGES = 1;

  // vld_pipe[0] marks a read on this edge. vld_pipe[1] marks that do_int
  // was refreshed by a read on the previous edge.
  logic [STAGES:0]       vld_pipe;
  logic [DATA_WIDTH-1:0] do_q;

  assign vld_pipe[0] = rd_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_pipe[STAGES:1] <= '0;
    else     vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               do_q <= '0;
    else if (vld_pipe[1])  do_q <= do_int;
  end

  assign dout = do_q;
`else
  assign dout = do_int;
`endif

endmodule

// File: tb/tb_ram_infr.sv
// Directed self-checking bench for ram_infr in its default configuration.
// Stimulus changes on the falling edge. Outputs are sampled 1 time unit after
// the rising edge, except for the asynchronous reset checks, which sample
// between edges.

module tb_ram_infr;

  localparam int DW = 4;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic          en;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] di;
  logic [DW-1:0] dout;

  int n_cmp;
  int n_bad;

  ram_infr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .we   (we),
    .addr (addr),
    .di   (di),
    .dout (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle at the falling edge, then settle just after the rising edge.
  task automatic cyc(input logic e, input logic w, input logic [AW-1:0] a,
                     input logic [DW-1:0] d);
    @(negedge clk);
    en = e; we = w; addr = a; di = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; we = 1'b0; addr = '0; di = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (dout !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_dout: got %b want %b", dout, 4'b0000);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write_read;
    cyc(1'b1, 1'b1, 5'd6, 4'b1010);
    n_cmp++;
    if (dout !== 4'b0000) begin
      n_bad++;
      $display("FAIL wr_nochange_first: got %b want %b", dout, 4'b0000);
    end
    cyc(1'b1, 1'b1, 5'd12, 4'b1100);
    cyc(1'b1, 1'b0, 5'd6, 4'b0000);
    n_cmp++;
    if (dout !== 4'b1010) begin
      n_bad++;
      $display("FAIL rd_addr6: got %b want %b", dout, 4'b1010);
    end
    cyc(1'b1, 1'b0, 5'd12, 4'b0000);
    n_cmp++;
    if (dout !== 4'b1100) begin
      n_bad++;
      $display("FAIL rd_addr12: got %b want %b", dout, 4'b1100);
    end
  endtask

  task automatic test_disable_hold;
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0, 5'd0, 4'b0000);
      n_cmp++;
      if (dout !== 4'b1100) begin
        n_bad++;
        $display("FAIL disable_hold[%0d]: got %b want %b", i, dout, 4'b1100);
      end
    end
  endtask

  task automatic test_nochange_write;
    cyc(1'b1, 1'b0, 5'd6, 4'b0000);
    n_cmp++;
    if (dout !== 4'b1010) begin
      n_bad++;
      $display("FAIL nochange_setup: got %b want %b", dout, 4'b1010);
    end
    cyc(1'b1, 1'b1, 5'd3, 4'b0111);
    n_cmp++;
    if (dout !== 4'b1010) begin
      n_bad++;
      $display("FAIL nochange_on_write: got %b want %b", dout, 4'b1010);
    end
    cyc(1'b1, 1'b0, 5'd3, 4'b0000);
    n_cmp++;
    if (dout !== 4'b0111) begin
      n_bad++;
      $display("FAIL rd_addr3: got %b want %b", dout, 4'b0111);
    end
  endtask

  task automatic test_write_ignored_disabled;
    cyc(1'b0, 1'b1, 5'd6, 4'b0001);
    n_cmp++;
    if (dout !== 4'b0111) begin
      n_bad++;
      $display("FAIL dis_write_hold: got %b want %b", dout, 4'b0111);
    end
    cyc(1'b1, 1'b0, 5'd6, 4'b0000);
    n_cmp++;
    if (dout !== 4'b1010) begin
      n_bad++;
      $display("FAIL dis_write_ignored: got %b want %b", dout, 4'b1010);
    end
  endtask

  task automatic test_async_reset;
    cyc(1'b1, 1'b0, 5'd12, 4'b0000);
    n_cmp++;
    if (dout !== 4'b1100) begin
      n_bad++;
      $display("FAIL arst_setup: got %b want %b", dout, 4'b1100);
    end
    // Assert reset between edges while a read is still being presented.
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (dout !== 4'b0000) begin
      n_bad++;
      $display("FAIL arst_async_clear: got %b want %b", dout, 4'b0000);
    end
    // A write attempted during reset must be suppressed.
    @(negedge clk);
    en = 1'b1; we = 1'b1; addr = 5'd12; di = 4'b0011;
    @(posedge clk);
    #1;
    n_cmp++;
    if (dout !== 4'b0000) begin
      n_bad++;
      $display("FAIL arst_hold: got %b want %b", dout, 4'b0000);
    end
    @(negedge clk);
    rst = 1'b0; en = 1'b0; we = 1'b0;
    cyc(1'b1, 1'b0, 5'd12, 4'b0000);
    n_cmp++;
    if (dout !== 4'b1100) begin
      n_bad++;
      $display("FAIL arst_mem_retained: got %b want %b", dout, 4'b1100);
    end
  endtask

  task automatic test_full_range;
    cyc(1'b1, 1'b1, 5'd0, 4'b0101);
    cyc(1'b1, 1'b1, 5'd31, 4'b1111);
    cyc(1'b1, 1'b0, 5'd0, 4'b0000);
    n_cmp++;
    if (dout !== 4'b0101) begin
      n_bad++;
      $display("FAIL rd_addr0: got %b want %b", dout, 4'b0101);
    end
    cyc(1'b1, 1'b0, 5'd31, 4'b0000);
    n_cmp++;
    if (dout !== 4'b1111) begin
      n_bad++;
      $display("FAIL rd_addr31: got %b want %b", dout, 4'b1111);
    end
  endtask

  task automatic test_back_to_back;
    logic [AW-1:0] a_tab [4];
    logic [DW-1:0] e_tab [4];
    a_tab[0] = 5'd6;  e_tab[0] = 4'b1010;
    a_tab[1] = 5'd12; e_tab[1] = 4'b1100;
    a_tab[2] = 5'd3;  e_tab[2] = 4'b0111;
    a_tab[3] = 5'd0;  e_tab[3] = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, a_tab[i], 4'b0000);
      n_cmp++;
      if (dout !== e_tab[i]) begin
        n_bad++;
        $display("FAIL b2b_rd[%0d]: got %b want %b", i, dout, e_tab[i]);
      end
    end
    // The last write to an address wins.
    cyc(1'b1, 1'b1, 5'd3, 4'b0001);
    cyc(1'b1, 1'b1, 5'd3, 4'b1001);
    cyc(1'b1, 1'b0, 5'd3, 4'b0000);
    n_cmp++;
    if (dout !== 4'b1001) begin
      n_bad++;
      $display("FAIL last_write_wins: got %b want %b", dout, 4'b1001);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_write_read();
    test_disable_hold();
    test_nochange_write();
    test_write_ignored_disabled();
    test_async_reset();
    test_full_range();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
